// File: rtl/cpu_pkg.sv
// Shared opcode constants, result-unit state encoding and datapath defaults.
package cpu_pkg;
    localparam int DW_DEF  = 32;
    localparam int OPW_DEF = 5;

    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;
endpackage

// File: rtl/hilo_regs.sv
// HI/LO register pair with independent per-word write enables.
module hilo_regs #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_hi_we,
    input  logic [DW-1:0] i_hi_d,
    input  logic          i_lo_we,
    input  logic [DW-1:0] i_lo_d,
    output logic [DW-1:0] o_hi_q,
    output logic [DW-1:0] o_lo_q
);
    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_lo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (i_hi_we) r_hi <= i_hi_d;
            if (i_lo_we) r_lo <= i_lo_d;
        end
    end

    assign o_hi_q = r_hi;
    assign o_lo_q = r_lo;
endmodule

// File: rtl/z_result_unit.sv
// ALU result stage: captures a 2*DW result into Z, drains it word-by-word onto
// the bus, commits Mul/Div results to HI/LO and keeps zero/negative flags.
module z_result_unit
    import cpu_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2*DW-1:0] c_in,
    input  logic [OPW-1:0]  op,
    input  logic            z_in,
    input  logic            bus_rdy,
    output logic [DW-1:0]   bus_out,
    output logic            bus_vld,
    output logic            busy,
    output logic [DW-1:0]   hi_q,
    output logic [DW-1:0]   lo_q,
    output logic            zero_flag,
    output logic            neg_flag,
    output logic            overrun
);
    state_t          r_state;
    logic [2*DW-1:0] r_z;
    logic [OPW-1:0]  r_op;
    logic            r_zero;
    logic            r_neg;
    logic            r_ovr;

    logic            w_two_q;
    logic            w_two_in;
    logic            w_last;
    logic            w_busy;
    logic            w_acc;
    logic [2*DW-1:0] w_cap;
    logic            w_hi_we;
    logic            w_lo_we;

    assign w_two_q  = (r_op == OPW'(OP_MUL)) || (r_op == OPW'(OP_DIV));
    assign w_two_in = (op == OPW'(OP_MUL)) || (op == OPW'(OP_DIV));

    // The last word of a drain frees the unit in the same cycle so a new
    // capture can follow with no bubble.
    assign w_last = ((r_state == LO) && !w_two_q) || (r_state == HI);
    assign w_busy = (r_state != IDLE) && !(w_last && bus_rdy);
    assign w_acc  = z_in && !w_busy;

    // Mfhi/Mflo read HI/LO as they stand before any commit on this edge.
    always_comb begin
        w_cap = c_in;
        if (op == OPW'(OP_MFHI))      w_cap = {{DW{1'b0}}, hi_q};
        else if (op == OPW'(OP_MFLO)) w_cap = {{DW{1'b0}}, lo_q};
    end

    assign w_lo_we = (r_state == LO) && w_two_q && bus_rdy;
    assign w_hi_we = (r_state == HI) && bus_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_z     <= '0;
            r_op    <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_z     <= w_cap;
                r_op    <= op;
                r_state <= LO;
                if (w_two_in) begin
                    r_zero <= (c_in == '0);
                    r_neg  <= c_in[2*DW-1];
                end else begin
                    r_zero <= (c_in[DW-1:0] == '0);
                    r_neg  <= c_in[DW-1];
                end
            end else begin
                case (r_state)
                    LO:      if (bus_rdy) r_state <= w_two_q ? HI : IDLE;
                    HI:      if (bus_rdy) r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
            if (z_in && w_busy) r_ovr <= 1'b1;
        end
    end

    hilo_regs #(.DW(DW)) u_hilo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_hi_we (w_hi_we),
        .i_hi_d  (r_z[2*DW-1:DW]),
        .i_lo_we (w_lo_we),
        .i_lo_d  (r_z[DW-1:0]),
        .o_hi_q  (hi_q),
        .o_lo_q  (lo_q)
    );

    always_comb begin
        bus_out = '0;
        if (r_state == LO)      bus_out = r_z[DW-1:0];
        else if (r_state == HI) bus_out = r_z[2*DW-1:DW];
    end

    assign bus_vld   = (r_state != IDLE);
    assign busy      = w_busy;
    assign zero_flag = r_zero;
    assign neg_flag  = r_neg;
    assign overrun   = r_ovr;
endmodule

// File: tb/tb_z_result_unit.sv
// Bench for z_result_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a word-queue model.
module tb_z_result_unit;
    import cpu_pkg::*;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] c_in;
    logic [4:0]  op;
    logic        z_in;
    logic        bus_rdy;
    logic [31:0] bus_out;
    logic        bus_vld;
    logic        busy;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        zero_flag;
    logic        neg_flag;
    logic        overrun;

    int n_chk  = 0;
    int n_pass = 0;

    z_result_unit #(.DW(32), .OPW(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .c_in      (c_in),
        .op        (op),
        .z_in      (z_in),
        .bus_rdy   (bus_rdy),
        .bus_out   (bus_out),
        .bus_vld   (bus_vld),
        .busy      (busy),
        .hi_q      (hi_q),
        .lo_q      (lo_q),
        .zero_flag (zero_flag),
        .neg_flag  (neg_flag),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    endtask

    // Model: the pending bus words in order, each tagged with where it
    // commits on acceptance (0 nowhere, 1 LO, 2 HI).
    logic [31:0] m_w[$];
    int          m_c[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_zero = 1'b0, m_neg = 1'b0, m_ovr = 1'b0;

    always @(negedge clk) begin
        int          sz;
        logic        bexp;
        logic [31:0] old_hi, old_lo;
        if (!reset_n) begin
            m_w.delete(); m_c.delete();
            m_hi = '0; m_lo = '0; m_zero = 1'b0; m_neg = 1'b0; m_ovr = 1'b0;
        end
        sz   = m_w.size();
        bexp = (sz > 0) && !(sz == 1 && bus_rdy);
        chk("m_bus_vld", {63'd0, bus_vld}, {63'd0, sz > 0});
        chk("m_bus_out", {32'd0, bus_out}, {32'd0, (sz > 0) ? m_w[0] : 32'd0});
        chk("m_busy", {63'd0, busy}, {63'd0, bexp});
        chk("m_hi_q", {32'd0, hi_q}, {32'd0, m_hi});
        chk("m_lo_q", {32'd0, lo_q}, {32'd0, m_lo});
        chk("m_zero", {63'd0, zero_flag}, {63'd0, m_zero});
        chk("m_neg", {63'd0, neg_flag}, {63'd0, m_neg});
        chk("m_ovr", {63'd0, overrun}, {63'd0, m_ovr});
        if (reset_n) begin
            old_hi = m_hi;
            old_lo = m_lo;
            if (sz > 0 && bus_rdy) begin
                if (m_c[0] == 1) m_lo = m_w[0];
                else if (m_c[0] == 2) m_hi = m_w[0];
                void'(m_w.pop_front());
                void'(m_c.pop_front());
            end
            if (z_in && bexp) m_ovr = 1'b1;
            if (z_in && !bexp) begin
                if (op == OP_MUL || op == OP_DIV) begin
                    m_w.push_back(c_in[31:0]);  m_c.push_back(1);
                    m_w.push_back(c_in[63:32]); m_c.push_back(2);
                    m_zero = (c_in == 64'd0);
                    m_neg  = c_in[63];
                end else begin
                    if (op == OP_MFHI)      m_w.push_back(old_hi);
                    else if (op == OP_MFLO) m_w.push_back(old_lo);
                    else                    m_w.push_back(c_in[31:0]);
                    m_c.push_back(0);
                    m_zero = (c_in[31:0] == 32'd0);
                    m_neg  = c_in[31];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [4:0] o, input logic [63:0] c, input logic rdy);
        z_in = 1'b1; op = o; c_in = c; bus_rdy = rdy;
    endtask

    initial begin
        reset_n = 1'b1; z_in = 1'b0; op = '0; c_in = '0; bus_rdy = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_vld", {63'd0, bus_vld}, 64'd0);
        chk("rst_out", {32'd0, bus_out}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hilo", {hi_q, lo_q}, 64'd0);
        chk("rst_flags", {61'd0, zero_flag, neg_flag, overrun}, 64'd0);
        step(); step();
        reset_n = 1'b1;
        step();

        // single-word Add
        cap(OP_ADD, 64'h0000_0000_0000_0005, 1'b1);
        step(); z_in = 1'b0;
        chk("add_vld", {63'd0, bus_vld}, 64'd1);
        chk("add_out", {32'd0, bus_out}, 64'd5);
        step();
        chk("add_idle", {63'd0, bus_vld}, 64'd0);
        chk("add_hilo", {hi_q, lo_q}, 64'd0);
        chk("add_flags", {62'd0, zero_flag, neg_flag}, 64'd0);

        // Mul drains lo then hi and commits both
        cap(OP_MUL, 64'h0000_0001_FFFF_FFFE, 1'b1);
        step(); z_in = 1'b0;
        chk("mul_w0", {32'd0, bus_out}, 64'hFFFF_FFFE);
        chk("mul_busy0", {63'd0, busy}, 64'd1);
        step();
        chk("mul_w1", {32'd0, bus_out}, 64'h1);
        chk("mul_lo", {32'd0, lo_q}, 64'hFFFF_FFFE);
        chk("mul_neg", {63'd0, neg_flag}, 64'd0);
        step();
        chk("mul_hi", {32'd0, hi_q}, 64'h1);

        // Mfhi / Mflo
        cap(OP_MFHI, 64'h0, 1'b1);
        step(); z_in = 1'b0;
        chk("mfhi_out", {32'd0, bus_out}, 64'h1);
        step();
        chk("mfhi_hi", {32'd0, hi_q}, 64'h1);
        cap(OP_MFLO, 64'h0, 1'b1);
        step(); z_in = 1'b0;
        chk("mflo_out", {32'd0, bus_out}, 64'hFFFF_FFFE);
        step();

        // Div with a 3-cycle stall
        cap(OP_DIV, {32'd3, 32'd7}, 1'b0);
        step(); z_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("div_stall_out", {32'd0, bus_out}, 64'd7);
            chk("div_stall_busy", {63'd0, busy}, 64'd1);
            if (i < 2) step();
        end
        bus_rdy = 1'b1;
        step();
        chk("div_rem", {32'd0, bus_out}, 64'd3);
        chk("div_lo", {32'd0, lo_q}, 64'd7);
        step();
        chk("div_hi", {32'd0, hi_q}, 64'd3);

        // overrun while stalled
        cap(OP_SUB, 64'h0000_0000_8000_0000, 1'b0);
        step();
        chk("sub_neg", {63'd0, neg_flag}, 64'd1);
        op = OP_ADD; c_in = 64'h1234;
        step(); z_in = 1'b0;
        chk("ovr_set", {63'd0, overrun}, 64'd1);
        chk("ovr_out", {32'd0, bus_out}, 64'h8000_0000);
        bus_rdy = 1'b1;
        step();

        // back-to-back capture on the final drain cycle
        cap(OP_ADD, 64'd9, 1'b1);
        step();
        op = OP_OR; c_in = 64'd0;
        #1;
        chk("b2b_busy", {63'd0, busy}, 64'd0);
        chk("b2b_out0", {32'd0, bus_out}, 64'd9);
        step(); z_in = 1'b0;
        chk("b2b_vld", {63'd0, bus_vld}, 64'd1);
        chk("b2b_out1", {32'd0, bus_out}, 64'd0);
        chk("b2b_zero", {63'd0, zero_flag}, 64'd1);
        step();

        // reset in the middle of a Mul drain
        cap(OP_MUL, {32'hDEAD_BEEF, 32'h1234_5678}, 1'b1);
        step(); z_in = 1'b0;
        step();
        chk("mrst_hiword", {32'd0, bus_out}, 64'hDEAD_BEEF);
        chk("mrst_lo_pre", {32'd0, lo_q}, 64'h1234_5678);
        reset_n = 1'b0;
        #1;
        chk("mrst_vld", {63'd0, bus_vld}, 64'd0);
        chk("mrst_out", {32'd0, bus_out}, 64'd0);
        chk("mrst_hilo", {hi_q, lo_q}, 64'd0);
        chk("mrst_ovr", {63'd0, overrun}, 64'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("mrst_hi_after", {32'd0, hi_q}, 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int sel;
            z_in    = ($urandom_range(0, 2) == 0);
            bus_rdy = ($urandom_range(0, 3) != 0);
            sel     = $urandom_range(0, 7);
            case (sel)
                0: op = OP_MUL;
                1: op = OP_DIV;
                2: op = OP_MFHI;
                3: op = OP_MFLO;
                default: op = 5'($urandom_range(0, 31));
            endcase
            case ($urandom_range(0, 7))
                0: c_in = 64'd0;
                1: c_in = {$urandom, 32'd0};
                default: c_in = {$urandom, $urandom};
            endcase
            reset_n = ($urandom_range(0, 299) != 0);
            step();
        end
        reset_n = 1'b1; z_in = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
